// File: rtl/axi3_pkg.sv
// Shared AXI3 encodings and master FSM state type for the AXI3 read/write masters.
package axi3_pkg;

  localparam logic [2:0] SizeWord   = 3'b010;
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] LockNormal = 2'b00;
  localparam logic [3:0] CacheNone  = 4'b0000;
  localparam logic [2:0] ProtNone   = 3'b000;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExOkay = 2'b01;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  localparam int unsigned WordCntW  = 15;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StDone
  } axi3_state_e;

  // SLVERR and DECERR both carry bit 1 set.
  function automatic logic resp_is_err(logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi3_mst_read_if.sv
// AXI3 read address and read data channels between one master and one slave.
interface axi3_mst_read_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi3_burst_len.sv
// Beats for the next INCR burst: min(MaxBeats, remaining words, words to the next 4 KB page).
module axi3_burst_len #(
  parameter int unsigned MaxBeats = 16
) (
  input  logic [31:0] addr_i,
  input  logic [14:0] remain_i,
  output logic [4:0]  beats_o
);

  logic [10:0] to_bound;
  logic [14:0] lim;
  logic [1:0]  unused_addr;

  assign unused_addr = addr_i[1:0];

  always_comb begin
    // addr_i[11:2] is the word offset within the page, so this is 1..1024.
    to_bound = 11'd1024 - {1'b0, addr_i[11:2]};
    lim      = 15'(MaxBeats);
    if (remain_i < lim) begin
      lim = remain_i;
    end
    if ({4'b0, to_bound} < lim) begin
      lim = {4'b0, to_bound};
    end
    beats_o = lim[4:0];
  end

endmodule

// File: rtl/axi3_mst_read.sv
// AXI3 read master: splits a byte-length transfer into INCR bursts and pushes every beat
// into the CRC data FIFO, one burst outstanding at a time.
module axi3_mst_read
  import axi3_pkg::*;
#(
  parameter logic [3:0]  ARID_VAL  = 4'h0,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr_src,
  input  logic [15:0] data_len,
  input  logic        mst_begin,
  input  logic        fifo_full,
  output logic        fifo_wr,
  output logic [31:0] fifo_out,
  output logic        data_read,
  output logic        error,
  axi3_mst_read_if.master axi
);

  axi3_state_e         state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [WordCntW-1:0] remain_q, remain_d;
  logic [4:0]          beats_q, beats_d;
  logic [4:0]          beat_cnt_q, beat_cnt_d;
  logic                err_q, err_d;
  logic                drain_q, drain_d;

  logic [16:0]         len_plus;
  logic [WordCntW-1:0] words;
  logic [4:0]          burst_beats;
  logic [4:0]          beats_m1;
  logic                beat_ok;
  logic [5:0]          unused_in;

  assign unused_in = {axi.rid, addr_src[1:0]};

  assign len_plus = {1'b0, data_len} + 17'd3;
  assign words    = len_plus[16:2];

  axi3_burst_len #(
    .MaxBeats (MAX_BEATS)
  ) u_burst_len (
    .addr_i   (addr_q),
    .remain_i (remain_q),
    .beats_o  (burst_beats)
  );

  assign beats_m1 = burst_beats - 5'd1;

  // AR channel: fields come straight from registered state, so they hold while arvalid waits.
  assign axi.arid    = ARID_VAL;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = (state_q == StAddr) ? beats_m1[3:0] : 4'd0;
  assign axi.arsize  = SizeWord;
  assign axi.arburst = BurstIncr;
  assign axi.arlock  = LockNormal;
  assign axi.arcache = CacheNone;
  assign axi.arprot  = ProtNone;
  assign axi.arvalid = (state_q == StAddr);

  assign axi.rready = (state_q == StData) && !fifo_full;
  assign beat_ok    = axi.rready && axi.rvalid;

  assign fifo_wr   = beat_ok;
  assign fifo_out  = beat_ok ? axi.rdata : 32'd0;
  assign data_read = (state_q == StDone);
  assign error     = err_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    beats_d    = beats_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    drain_d    = drain_q;

    unique case (state_q)
      StIdle: begin
        if (mst_begin) begin
          err_d      = 1'b0;
          drain_d    = 1'b0;
          beat_cnt_d = 5'd0;
          if (words == '0) begin
            state_d = StDone;
          end else begin
            addr_d   = {addr_src[31:2], 2'b00};
            remain_d = words;
            state_d  = StAddr;
          end
        end
      end

      StAddr: begin
        if (axi.arready) begin
          beats_d    = burst_beats;
          beat_cnt_d = 5'd0;
          state_d    = StData;
        end
      end

      StData: begin
        if (beat_ok) begin
          remain_d   = (remain_q != '0) ? remain_q - 1'b1 : '0;
          beat_cnt_d = beat_cnt_q + 5'd1;
          if (resp_is_err(axi.rresp)) begin
            err_d   = 1'b1;
            drain_d = 1'b1;
          end
          if (axi.rlast) begin
            addr_d = addr_q + {25'd0, beats_q, 2'b00};
            if (beat_cnt_d != beats_q) begin
              // Slave ended the burst short: the stream is corrupt, abandon the transfer.
              err_d   = 1'b1;
              state_d = StDone;
            end else if (drain_d || remain_d == '0) begin
              state_d = StDone;
            end else begin
              state_d = StAddr;
            end
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= 32'd0;
      remain_q   <= '0;
      beats_q    <= 5'd0;
      beat_cnt_q <= 5'd0;
      err_q      <= 1'b0;
      drain_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      beats_q    <= beats_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      drain_q    <= drain_d;
    end
  end

endmodule

// File: tb/tb_axi3_mst_read.sv
// Bench for axi3_mst_read: randomized-timing AXI3 slave plus AR and FIFO-data scoreboards.
module tb_axi3_mst_read;

  localparam logic [3:0] ArId = 4'h5;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
  } ar_exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr_src;
  logic [15:0] data_len;
  logic        mst_begin;
  logic        fifo_full;
  logic        fifo_wr;
  logic [31:0] fifo_out;
  logic        data_read;
  logic        error;

  axi3_mst_read_if bus();

  axi3_mst_read #(
    .ARID_VAL  (ArId),
    .MAX_BEATS (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr_src  (addr_src),
    .data_len  (data_len),
    .mst_begin (mst_begin),
    .fifo_full (fifo_full),
    .fifo_wr   (fifo_wr),
    .fifo_out  (fifo_out),
    .data_read (data_read),
    .error     (error),
    .axi       (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  ar_exp_t     exp_ar[$];
  logic [31:0] exp_data[$];
  int          exp_words, exp_bursts;

  int fifo_wr_cnt = 0, done_cnt = 0, ar_cnt = 0;
  int base_wr, base_done, base_ar;

  // Handshakes seen at the last falling edge, consumed by the slave after the next rising edge.
  logic        ar_hs_seen = 1'b0, r_hs_seen = 1'b0;
  logic [31:0] ar_addr_seen;
  logic [3:0]  ar_len_seen;
  logic        ar_pend = 1'b0;
  logic [31:0] pend_addr;
  logic [3:0]  pend_len;

  bit          s_busy = 1'b0;
  logic [31:0] s_addr;
  int          s_len, s_beat, s_burst_no;
  int          err_beat = -1, early_beat = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // Slave: random arready/rvalid timing; rvalid holds until accepted.
  initial begin
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = 32'd0;
    bus.rresp   = 2'b00;
    bus.rlast   = 1'b0;
    bus.rid     = 4'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        s_busy      = 1'b0;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rlast   = 1'b0;
      end else begin
        if (r_hs_seen) begin
          if (bus.rlast) begin
            s_busy = 1'b0;
            s_burst_no++;
          end else begin
            s_beat++;
          end
        end
        if (ar_hs_seen) begin
          s_busy = 1'b1;
          s_addr = ar_addr_seen;
          s_len  = int'(ar_len_seen) + 1;
          s_beat = 0;
        end
        bus.arready = !s_busy && ($urandom_range(0, 2) != 0);
        if (s_busy) begin
          if (!bus.rvalid || r_hs_seen) bus.rvalid = ($urandom_range(0, 3) != 0);
          bus.rdata = beat_data(s_addr + 32'(4 * s_beat));
          bus.rlast = (s_beat == s_len - 1) || (s_burst_no == 0 && s_beat == early_beat);
          bus.rresp = (s_burst_no == 0 && s_beat == err_beat) ? 2'b10 : 2'b00;
          bus.rid   = ArId;
        end else begin
          bus.rvalid = 1'b0;
          bus.rlast  = 1'b0;
          bus.rresp  = 2'b00;
        end
      end
    end
  end

  // Monitor: scoreboard pops on AR handshakes and FIFO pushes.
  initial begin
    ar_exp_t     e;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      ar_hs_seen   = bus.arvalid && bus.arready;
      ar_addr_seen = bus.araddr;
      ar_len_seen  = bus.arlen;
      r_hs_seen    = bus.rvalid && bus.rready;
      if (!rst_n) begin
        ar_pend = 1'b0;
      end else begin
        if (bus.arvalid) begin
          check("ar_one_outstanding", 32'(s_busy), 32'd0);
          if (ar_pend) begin
            check("ar_stable_addr", bus.araddr, pend_addr);
            check("ar_stable_len", 32'(bus.arlen), 32'(pend_len));
          end
        end
        if (ar_hs_seen) begin
          ar_cnt++;
          check("ar_const", {14'd0, bus.arid, bus.arsize, bus.arburst, bus.arlock, bus.arcache,
                             bus.arprot}, {14'd0, ArId, 3'b010, 2'b01, 2'b00, 4'b0000, 3'b000});
          if (exp_ar.size() == 0) begin
            check("ar_unexpected", 32'(exp_ar.size()), 32'd1);
          end else begin
            e = exp_ar.pop_front();
            check("araddr", bus.araddr, e.addr);
            check("arlen", 32'(bus.arlen), 32'(e.len));
          end
        end
        ar_pend   = bus.arvalid && !bus.arready;
        pend_addr = bus.araddr;
        pend_len  = bus.arlen;
        if (fifo_wr) begin
          fifo_wr_cnt++;
          if (exp_data.size() == 0) begin
            check("fifo_unexpected", 32'(exp_data.size()), 32'd1);
          end else begin
            d = exp_data.pop_front();
            check("fifo_out", fifo_out, d);
          end
        end
        if (fifo_full) begin
          check("full_rready", 32'(bus.rready), 32'd0);
          check("full_fifo_wr", 32'(fifo_wr), 32'd0);
        end
        if (data_read) done_cnt++;
      end
    end
  end

  task automatic pulse_begin(input logic [31:0] a, input logic [15:0] len);
    @(posedge clk);
    #1;
    addr_src  = a;
    data_len  = len;
    mst_begin = 1'b1;
    @(posedge clk);
    #1;
    mst_begin = 1'b0;
  endtask

  // Expected bursts/words from the page-split rule; limits model early termination.
  task automatic start_xfer(input logic [31:0] a, input logic [15:0] len,
                            input int max_bursts, input int max_words);
    int          rem, tob, b, nb, nw;
    logic [31:0] wa;
    rem = (int'(len) + 3) / 4;
    wa  = {a[31:2], 2'b00};
    nb  = 0;
    nw  = 0;
    while (rem > 0 && (max_bursts < 0 || nb < max_bursts)) begin
      tob = (4096 - int'(wa[11:0])) / 4;
      b   = (rem < 16) ? rem : 16;
      if (tob < b) b = tob;
      exp_ar.push_back('{addr: wa, len: 4'(b - 1)});
      for (int i = 0; i < b; i++) begin
        if (max_words < 0 || nw < max_words) begin
          exp_data.push_back(beat_data(wa + 32'(4 * i)));
          nw++;
        end
      end
      wa  = wa + 32'(4 * b);
      rem = rem - b;
      nb++;
    end
    exp_words  = nw;
    exp_bursts = nb;
    base_wr    = fifo_wr_cnt;
    base_done  = done_cnt;
    base_ar    = ar_cnt;
    s_burst_no = 0;
    pulse_begin(a, len);
  endtask

  task automatic finish_xfer(input string tag, input int budget, input logic exp_err);
    int n;
    n = 0;
    while (done_cnt == base_done && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt > base_done), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({tag, "_done_once"}, 32'(done_cnt - base_done), 32'd1);
    check({tag, "_words"}, 32'(fifo_wr_cnt - base_wr), 32'(exp_words));
    check({tag, "_bursts"}, 32'(ar_cnt - base_ar), 32'(exp_bursts));
    check({tag, "_ar_left"}, 32'(exp_ar.size()), 32'd0);
    check({tag, "_data_left"}, 32'(exp_data.size()), 32'd0);
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    err_beat   = -1;
    early_beat = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arvalid"}, 32'(bus.arvalid), 32'd0);
    check({tag, "_araddr"}, bus.araddr, 32'd0);
    check({tag, "_arlen"}, 32'(bus.arlen), 32'd0);
    check({tag, "_rready"}, 32'(bus.rready), 32'd0);
    check({tag, "_fifo_wr"}, 32'(fifo_wr), 32'd0);
    check({tag, "_fifo_out"}, fifo_out, 32'd0);
    check({tag, "_data_read"}, 32'(data_read), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    addr_src  = 32'd0;
    data_len  = 16'd0;
    mst_begin = 1'b0;
    fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 84 words: five 16-beat bursts then 4; a stray mst_begin mid-transfer is ignored.
    start_xfer(32'h0000_1000, 16'd333, -1, -1);
    repeat (10) @(posedge clk);
    pulse_begin(32'h0000_8000, 16'd40);
    finish_xfer("len333", 3000, 1'b0);

    // Crosses a 4 KB page: 2 beats then 14.
    start_xfer(32'h0000_0FF8, 16'd64, -1, -1);
    finish_xfer("page", 1000, 1'b0);

    // FIFO back-pressure for 5 cycles mid-burst.
    start_xfer(32'h0000_3000, 16'd128, -1, -1);
    n = 0;
    while (fifo_wr_cnt - base_wr < 5 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("full_start_seen", 32'(fifo_wr_cnt - base_wr >= 5), 32'd1);
    @(posedge clk);
    #1;
    fifo_full = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    fifo_full = 1'b0;
    finish_xfer("full", 2000, 1'b0);

    // SLVERR on beat 3: drain the 16-beat burst, no second AR.
    err_beat = 2;
    start_xfer(32'h0000_4000, 16'd256, 1, -1);
    finish_xfer("slverr", 1000, 1'b1);

    // Short burst: rlast on beat 6 of an expected 16.
    early_beat = 5;
    start_xfer(32'h0000_5000, 16'd64, 1, 6);
    finish_xfer("early", 1000, 1'b1);

    // Zero length: no AR traffic, prompt done, error cleared.
    start_xfer(32'h0000_6000, 16'd0, -1, -1);
    finish_xfer("len0", 3, 1'b0);

    // Single byte and address wrap past 2^32.
    start_xfer(32'h0000_7003, 16'd1, -1, -1);
    finish_xfer("len1", 500, 1'b0);
    start_xfer(32'hFFFF_FFF0, 16'd32, -1, -1);
    finish_xfer("wrap", 1000, 1'b0);

    // Reset during DATA, then a clean transfer.
    start_xfer(32'h0000_2000, 16'd256, -1, -1);
    n = 0;
    while (fifo_wr_cnt - base_wr < 3 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("rst_mid_seen", 32'(fifo_wr_cnt - base_wr >= 3), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    exp_ar.delete();
    exp_data.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_hold");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    start_xfer(32'h0000_9004, 16'd100, -1, -1);
    finish_xfer("after_rst", 2000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
